// File: rtl/eth_f_pkt_stat_pkg.sv
// Shared types and helpers for the Ethernet packet statistics bank.
// Snapshot FSM states, pipeline depth and the per-cycle increment width.
package eth_f_pkt_stat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LATCH = 2'd2
  } snap_state_t;

  localparam int PIPE_DEPTH = 3;

  function automatic int f_inc_w(input int words);
    return $clog2(words + 1);
  endfunction

endpackage

// File: rtl/eth_f_pkt_stat_seg_detect.sv
// Segmented-interface boundary detector: S1 input register, S2 per-cycle
// SOP/EOP/errored-EOP counts plus a valid strobe.
module eth_f_pkt_stat_seg_detect
  import eth_f_pkt_stat_pkg::*;
#(
  parameter int WORDS         = 8,
  parameter int SEG_ERR_WIDTH = 2 * WORDS,
  parameter int INC_W         = f_inc_w(WORDS)
) (
  input  logic                     i_clk,
  input  logic                     rst,
  input  logic                     mac_valid,
  input  logic [WORDS-1:0]         mac_inframe,
  input  logic [SEG_ERR_WIDTH-1:0] mac_error,
  output logic                     inc_vld,
  output logic [INC_W-1:0]         sop_inc,
  output logic [INC_W-1:0]         eop_inc,
  output logic [INC_W-1:0]         err_inc
);

  logic                     s1_valid;
  logic [WORDS-1:0]         s1_inframe;
  logic [SEG_ERR_WIDTH-1:0] s1_error;
  logic                     last_inframe;
  logic [WORDS:0]           ext;
  logic [INC_W-1:0]         sop_n, eop_n, err_n;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_inframe <= '0;
      s1_error   <= '0;
    end else begin
      s1_valid   <= mac_valid;
      s1_inframe <= mac_inframe;
      s1_error   <= mac_error;
    end
  end

  // ext[k] is the previous-segment inframe of segment k; ext[k+1] is its own.
  always_comb begin
    ext   = {s1_inframe, last_inframe};
    sop_n = '0;
    eop_n = '0;
    err_n = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (ext[k+1] && !ext[k]) sop_n = sop_n + INC_W'(1);
      if (!ext[k+1] && ext[k]) begin
        eop_n = eop_n + INC_W'(1);
        if (|s1_error[2*k +: 2]) err_n = err_n + INC_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      inc_vld      <= 1'b0;
      last_inframe <= 1'b0;
      sop_inc      <= '0;
      eop_inc      <= '0;
      err_inc      <= '0;
    end else begin
      inc_vld <= s1_valid;
      if (s1_valid) begin
        last_inframe <= s1_inframe[WORDS-1];
        sop_inc      <= sop_n;
        eop_inc      <= eop_n;
        err_inc      <= err_n;
      end else begin
        sop_inc <= '0;
        eop_inc <= '0;
        err_inc <= '0;
      end
    end
  end

endmodule

// File: rtl/eth_f_pkt_stat_bank.sv
// Packet statistics bank: SOP/EOP/errored-EOP counters with snapshot handshake.
// Define ETH_F_PKT_STAT_SAT_EN to make counters saturate instead of wrapping.
module eth_f_pkt_stat_bank
  import eth_f_pkt_stat_pkg::*;
#(
  parameter int CLIENT_IF_TYPE = 1,
  parameter int WORDS          = 8,
  parameter int AVST_ERR_WIDTH = 8,
  parameter int SEG_ERR_WIDTH  = 2 * WORDS,
  parameter int CNT_W          = 32,
  parameter int CLR_ON_SNAP    = 0
) (
  input  logic                      i_clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic                      i_sop,
  input  logic                      i_eop,
  input  logic [AVST_ERR_WIDTH-1:0] i_error,
  input  logic                      i_mac_valid,
  input  logic [WORDS-1:0]          i_mac_inframe,
  input  logic [SEG_ERR_WIDTH-1:0]  i_mac_error,
  input  logic                      i_clr,
  input  logic                      i_snap_req,
  output logic                      o_snap_busy,
  output logic                      o_snap_vld,
  output logic [CNT_W-1:0]          o_sop_cnt,
  output logic [CNT_W-1:0]          o_eop_cnt,
  output logic [CNT_W-1:0]          o_err_cnt,
  output logic [2:0]                o_ovf
);

  localparam int INC_W = f_inc_w(WORDS);

  logic a1_valid, a1_sop, a1_eop, a1_err;
  logic a2_vld, a2_sop, a2_eop, a2_err;
  logic s2_vld;
  logic [INC_W-1:0] s2_sop, s2_eop, s2_err;

  logic                      inc_vld;
  logic [2:0][INC_W-1:0]     inc;
  logic [2:0][CNT_W-1:0]     cnt, cnt_nxt;
  logic [2:0]                ovf_hit;
  logic [CNT_W:0]            sum;
  snap_state_t               state;
  logic [1:0]                drain_cnt;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      a1_valid <= 1'b0;
      a1_sop   <= 1'b0;
      a1_eop   <= 1'b0;
      a1_err   <= 1'b0;
      a2_vld   <= 1'b0;
      a2_sop   <= 1'b0;
      a2_eop   <= 1'b0;
      a2_err   <= 1'b0;
    end else begin
      a1_valid <= i_valid;
      a1_sop   <= i_sop;
      a1_eop   <= i_eop;
      a1_err   <= |i_error;
      a2_vld   <= a1_valid;
      a2_sop   <= a1_valid & a1_sop;
      a2_eop   <= a1_valid & a1_eop;
      a2_err   <= a1_valid & a1_eop & a1_err;
    end
  end

  eth_f_pkt_stat_seg_detect #(
    .WORDS         (WORDS),
    .SEG_ERR_WIDTH (SEG_ERR_WIDTH),
    .INC_W         (INC_W)
  ) u_seg_detect (
    .i_clk       (i_clk),
    .rst         (rst),
    .mac_valid   (i_mac_valid),
    .mac_inframe (i_mac_inframe),
    .mac_error   (i_mac_error),
    .inc_vld     (s2_vld),
    .sop_inc     (s2_sop),
    .eop_inc     (s2_eop),
    .err_inc     (s2_err)
  );

  always_comb begin
    if (CLIENT_IF_TYPE == 1) begin
      inc_vld = a2_vld;
      inc[0]  = INC_W'(a2_sop);
      inc[1]  = INC_W'(a2_eop);
      inc[2]  = INC_W'(a2_err);
    end else begin
      inc_vld = s2_vld;
      inc[0]  = s2_sop;
      inc[1]  = s2_eop;
      inc[2]  = s2_err;
    end
    if (!inc_vld) inc = '0;
  end

  always_comb begin
    sum     = '0;
    cnt_nxt = '0;
    ovf_hit = '0;
    for (int i = 0; i < 3; i++) begin
      sum = {1'b0, cnt[i]} + (CNT_W + 1)'(inc[i]);
`ifdef ETH_F_PKT_STAT_SAT_EN
      cnt_nxt[i] = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      ovf_hit[i] = sum[CNT_W] | (&sum[CNT_W-1:0]);
`else
      cnt_nxt[i] = sum[CNT_W-1:0];
      ovf_hit[i] = sum[CNT_W];
`endif
    end
  end

  // With clear-on-snapshot the LATCH-cycle increment seeds the new window
  // rather than the snapshot, so each event lands in exactly one snapshot.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      o_ovf <= '0;
    end else if (i_clr) begin
      cnt   <= '0;
      o_ovf <= '0;
    end else if (CLR_ON_SNAP != 0 && state == LATCH) begin
      for (int i = 0; i < 3; i++) cnt[i] <= CNT_W'(inc[i]);
    end else begin
      cnt   <= cnt_nxt;
      o_ovf <= o_ovf | ovf_hit;
    end
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      drain_cnt  <= '0;
      o_snap_vld <= 1'b0;
      o_sop_cnt  <= '0;
      o_eop_cnt  <= '0;
      o_err_cnt  <= '0;
    end else begin
      o_snap_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (i_snap_req) begin
            state     <= DRAIN;
            drain_cnt <= 2'(PIPE_DEPTH);
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 2'd1;
          if (drain_cnt == 2'd1) state <= LATCH;
        end
        LATCH: begin
          o_sop_cnt  <= (CLR_ON_SNAP != 0) ? cnt[0] : cnt_nxt[0];
          o_eop_cnt  <= (CLR_ON_SNAP != 0) ? cnt[1] : cnt_nxt[1];
          o_err_cnt  <= (CLR_ON_SNAP != 0) ? cnt[2] : cnt_nxt[2];
          o_snap_vld <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_snap_busy = (state != IDLE);

endmodule

// File: tb/tb_eth_f_pkt_stat_bank.sv
// Bench for eth_f_pkt_stat_bank: AVST wrap/saturate, segmented detection,
// clear-on-snapshot, clear during latch, busy request drop, reset mid-snapshot.
module tb_eth_f_pkt_stat_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid, sop, eop;
  logic [7:0]  error;
  logic        mvalid;
  logic [7:0]  inframe;
  logic [15:0] merr;
  logic [2:0]  clr, snap;
  logic [2:0]  busy, svld;
  logic [7:0]  a_sop, a_eop, a_err;
  logic [15:0] s_sop, s_eop, s_err, c_sop, c_eop, c_err;
  logic [2:0]  a_ovf, s_ovf, c_ovf;

  int checks = 0;
  int errors = 0;

  // reference model state
  int a_m_sop = 0, a_m_eop = 0, a_m_err = 0;
  int m_sop = 0, m_eop = 0, m_err = 0;
  bit m_last = 1'b0;

  eth_f_pkt_stat_bank #(.CLIENT_IF_TYPE(1), .WORDS(8), .AVST_ERR_WIDTH(8), .CNT_W(8), .CLR_ON_SNAP(0)) u_avst (
    .i_clk(clk), .rst(rst), .i_valid(valid), .i_sop(sop), .i_eop(eop), .i_error(error),
    .i_mac_valid(mvalid), .i_mac_inframe(inframe), .i_mac_error(merr),
    .i_clr(clr[0]), .i_snap_req(snap[0]), .o_snap_busy(busy[0]), .o_snap_vld(svld[0]),
    .o_sop_cnt(a_sop), .o_eop_cnt(a_eop), .o_err_cnt(a_err), .o_ovf(a_ovf));

  eth_f_pkt_stat_bank #(.CLIENT_IF_TYPE(0), .WORDS(8), .AVST_ERR_WIDTH(8), .CNT_W(16), .CLR_ON_SNAP(0)) u_seg (
    .i_clk(clk), .rst(rst), .i_valid(valid), .i_sop(sop), .i_eop(eop), .i_error(error),
    .i_mac_valid(mvalid), .i_mac_inframe(inframe), .i_mac_error(merr),
    .i_clr(clr[1]), .i_snap_req(snap[1]), .o_snap_busy(busy[1]), .o_snap_vld(svld[1]),
    .o_sop_cnt(s_sop), .o_eop_cnt(s_eop), .o_err_cnt(s_err), .o_ovf(s_ovf));

  eth_f_pkt_stat_bank #(.CLIENT_IF_TYPE(1), .WORDS(8), .AVST_ERR_WIDTH(8), .CNT_W(16), .CLR_ON_SNAP(1)) u_cos (
    .i_clk(clk), .rst(rst), .i_valid(valid), .i_sop(sop), .i_eop(eop), .i_error(error),
    .i_mac_valid(mvalid), .i_mac_inframe(inframe), .i_mac_error(merr),
    .i_clr(clr[2]), .i_snap_req(snap[2]), .o_snap_busy(busy[2]), .o_snap_vld(svld[2]),
    .o_sop_cnt(c_sop), .o_eop_cnt(c_eop), .o_err_cnt(c_err), .o_ovf(c_ovf));

  function automatic int exp_cnt(input int total, input int w);
    int maxv;
    maxv = (1 << w) - 1;
`ifdef ETH_F_PKT_STAT_SAT_EN
    return (total > maxv) ? maxv : total;
`else
    return total % (maxv + 1);
`endif
  endfunction

  function automatic bit exp_ovf(input int total, input int w);
`ifdef ETH_F_PKT_STAT_SAT_EN
    return total >= ((1 << w) - 1);
`else
    return total >= (1 << w);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    valid = 1'b0; sop = 1'b0; eop = 1'b0; error = '0;
    mvalid = 1'b0; inframe = '0; merr = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic avst_beat(input logic v, input logic s, input logic e, input logic [7:0] er);
    valid = v; sop = s; eop = e; error = er;
    if (v && s) a_m_sop++;
    if (v && e) a_m_eop++;
    if (v && e && (er != 8'h00)) a_m_err++;
    @(negedge clk);
  endtask

  // Model treats the segments of consecutive valid cycles as one bit stream.
  task automatic seg_beat(input logic v, input logic [7:0] inf, input logic [15:0] er);
    mvalid = v; inframe = inf; merr = er;
    if (v) begin
      for (int k = 0; k < 8; k++) begin
        if (inf[k] && !m_last) m_sop++;
        if (!inf[k] && m_last) begin
          m_eop++;
          if (er[2*k +: 2] != 2'b00) m_err++;
        end
        m_last = inf[k];
      end
    end
    @(negedge clk);
  endtask

  task automatic seg_clear();
    idle(4);
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    m_sop = 0; m_eop = 0; m_err = 0;
  endtask

  // Requests a snapshot; optional clr pulse / second request at offset n
  // cycles after the request cycle. lat = -1 if no o_snap_vld was seen.
  task automatic do_snap(input int which, input int clr_at, input int req2_at,
                         output int lat, output int nvld, output int vs, output int ve,
                         output int vr, output logic [2:0] vo, output logic b1, output logic b5);
    lat = -1; nvld = 0; vs = 0; ve = 0; vr = 0; vo = '0; b1 = 1'b0; b5 = 1'b0;
    snap[which] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) snap[which] = 1'b0;
      if (n == req2_at) snap[which] = 1'b1;
      if (n == req2_at + 1) snap[which] = 1'b0;
      if (n == clr_at) clr[which] = 1'b1;
      if (n == clr_at + 1) clr[which] = 1'b0;
      if (n == 1) b1 = busy[which];
      if (n == 5) b5 = busy[which];
      if (svld[which]) begin
        nvld++;
        if (lat < 0) begin
          lat = n;
          case (which)
            0: begin vs = int'(a_sop); ve = int'(a_eop); vr = int'(a_err); vo = a_ovf; end
            1: begin vs = int'(s_sop); ve = int'(s_eop); vr = int'(s_err); vo = s_ovf; end
            default: begin vs = int'(c_sop); ve = int'(c_eop); vr = int'(c_err); vo = c_ovf; end
          endcase
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if ((a_sop | a_eop | a_err) !== 8'h00 || a_ovf !== 3'b000 || busy[0] !== 1'b0 || svld[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_avst got sop=%0d eop=%0d err=%0d ovf=%b busy=%b vld=%b exp all 0",
               a_sop, a_eop, a_err, a_ovf, busy[0], svld[0]);
    end
    checks++;
    if ((s_sop | s_eop | s_err) !== 16'h0 || s_ovf !== 3'b000 || busy[1] !== 1'b0 || svld[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_seg got sop=%0d eop=%0d err=%0d ovf=%b exp all 0", s_sop, s_eop, s_err, s_ovf);
    end
    checks++;
    if ((c_sop | c_eop | c_err) !== 16'h0 || c_ovf !== 3'b000 || busy[2] !== 1'b0 || svld[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_cos got sop=%0d eop=%0d err=%0d ovf=%b exp all 0", c_sop, c_eop, c_err, c_ovf);
    end
  endtask

  task automatic test_avst_wrap();
    bit is_err[300];
    int picked, len, lat, nvld, vs, ve, vr;
    logic [2:0] vo, exp_o;
    logic b1, b5;
    picked = 0;
    for (int p = 0; p < 300; p++) is_err[p] = 1'b0;
    while (picked < 5) begin
      int p;
      p = $urandom_range(0, 299);
      if (!is_err[p]) begin is_err[p] = 1'b1; picked++; end
    end
    for (int p = 0; p < 300; p++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0)
          avst_beat(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
        avst_beat(1'b1, b == 0, b == len - 1,
                  (b == len - 1) ? (is_err[p] ? 8'h01 : 8'h00) : 8'($urandom));
      end
    end
    idle(5);
    do_snap(0, -1, -1, lat, nvld, vs, ve, vr, vo, b1, b5);
    exp_o = {exp_ovf(a_m_err, 8), exp_ovf(a_m_eop, 8), exp_ovf(a_m_sop, 8)};
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL avst_latency got %0d exp 5", lat); end
    checks++;
    if (vs !== exp_cnt(a_m_sop, 8)) begin errors++; $display("FAIL avst_sop got %0d exp %0d", vs, exp_cnt(a_m_sop, 8)); end
    checks++;
    if (ve !== exp_cnt(a_m_eop, 8)) begin errors++; $display("FAIL avst_eop got %0d exp %0d", ve, exp_cnt(a_m_eop, 8)); end
    checks++;
    if (vr !== exp_cnt(a_m_err, 8)) begin errors++; $display("FAIL avst_err got %0d exp %0d", vr, exp_cnt(a_m_err, 8)); end
    checks++;
    if (vo !== exp_o) begin errors++; $display("FAIL avst_ovf got %b exp %b", vo, exp_o); end
    checks++;
    if (b1 !== 1'b1 || b5 !== 1'b0) begin errors++; $display("FAIL avst_busy got %b%b exp 10", b1, b5); end
  endtask

  task automatic test_seg_basic();
    int lat, nvld, vs, ve, vr;
    logic [2:0] vo;
    logic b1, b5;
    seg_clear();
    seg_beat(1'b1, 8'b0011_1100, 16'h3000);
    seg_beat(1'b1, 8'h00, 16'h0000);
    idle(4);
    do_snap(1, -1, -1, lat, nvld, vs, ve, vr, vo, b1, b5);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL seg_basic_latency got %0d exp 5", lat); end
    checks++;
    if (vs !== 1 || ve !== 1) begin errors++; $display("FAIL seg_basic_sop_eop got %0d/%0d exp 1/1", vs, ve); end
    checks++;
    if (vr !== 1) begin errors++; $display("FAIL seg_basic_err got %0d exp 1", vr); end
  endtask

  task automatic test_seg_gap();
    int lat, nvld, vs, ve, vr;
    logic [2:0] vo;
    logic b1, b5;
    seg_clear();
    seg_beat(1'b1, 8'hF0, 16'h0000);
    seg_beat(1'b0, 8'($urandom), 16'($urandom));
    seg_beat(1'b1, 8'hFF, 16'h0000);
    seg_beat(1'b0, 8'($urandom), 16'($urandom));
    seg_beat(1'b0, 8'($urandom), 16'($urandom));
    seg_beat(1'b1, 8'h07, 16'h0000);
    seg_beat(1'b1, 8'h00, 16'h0000);
    idle(4);
    do_snap(1, -1, -1, lat, nvld, vs, ve, vr, vo, b1, b5);
    checks++;
    if (vs !== 1) begin errors++; $display("FAIL seg_gap_sop got %0d exp 1", vs); end
    checks++;
    if (ve !== 1) begin errors++; $display("FAIL seg_gap_eop got %0d exp 1", ve); end
    checks++;
    if (vr !== 0) begin errors++; $display("FAIL seg_gap_err got %0d exp 0", vr); end
  endtask

  task automatic test_seg_random();
    int lat, nvld, vs, ve, vr;
    logic [2:0] vo;
    logic b1, b5;
    seg_clear();
    for (int i = 0; i < 200; i++)
      seg_beat($urandom_range(0, 3) != 0, 8'($urandom), 16'($urandom) & 16'($urandom));
    idle(4);
    do_snap(1, -1, -1, lat, nvld, vs, ve, vr, vo, b1, b5);
    checks++;
    if (vs !== exp_cnt(m_sop, 16)) begin errors++; $display("FAIL seg_rand_sop got %0d exp %0d", vs, exp_cnt(m_sop, 16)); end
    checks++;
    if (ve !== exp_cnt(m_eop, 16)) begin errors++; $display("FAIL seg_rand_eop got %0d exp %0d", ve, exp_cnt(m_eop, 16)); end
    checks++;
    if (vr !== exp_cnt(m_err, 16)) begin errors++; $display("FAIL seg_rand_err got %0d exp %0d", vr, exp_cnt(m_err, 16)); end
    checks++;
    if (nvld !== 1) begin errors++; $display("FAIL seg_rand_vld_count got %0d exp 1", nvld); end
  endtask

  task automatic test_clr_on_latch();
    int lat, nvld, vs, ve, vr;
    logic [2:0] vo;
    logic b1, b5;
    // model totals still hold the random test's traffic
    do_snap(1, 4, -1, lat, nvld, vs, ve, vr, vo, b1, b5);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL clr_latch_latency got %0d exp 5", lat); end
    checks++;
    if (vs !== exp_cnt(m_sop, 16) || ve !== exp_cnt(m_eop, 16) || vr !== exp_cnt(m_err, 16)) begin
      errors++;
      $display("FAIL clr_latch_snapshot got %0d/%0d/%0d exp %0d/%0d/%0d", vs, ve, vr,
               exp_cnt(m_sop, 16), exp_cnt(m_eop, 16), exp_cnt(m_err, 16));
    end
    m_sop = 0; m_eop = 0; m_err = 0;
    idle(2);
    do_snap(1, -1, -1, lat, nvld, vs, ve, vr, vo, b1, b5);
    checks++;
    if (vs !== 0 || ve !== 0 || vr !== 0) begin
      errors++; $display("FAIL clr_latch_after got %0d/%0d/%0d exp 0/0/0", vs, ve, vr);
    end
    checks++;
    if (vo !== 3'b000) begin errors++; $display("FAIL clr_latch_ovf got %b exp 000", vo); end
  endtask

  // Each event lands in exactly one snapshot window; the window of a request
  // at cycle R closes with the event presented at cycle R+1.
  task automatic test_clr_on_snap();
    int k, e1, e2;
    int cs[2], ce[2], cr[2];
    idle(4);
    clr[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0;
    k = 0; e1 = 0; e2 = 0;
    cs[0] = -1; cs[1] = -1; ce[0] = -1; ce[1] = -1; cr[0] = -1; cr[1] = -1;
    for (int i = 0; i <= 40; i++) begin
      valid = 1'b1; sop = 1'b1; eop = 1'b1;
      error = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if (error != 8'h00) begin
        if (i <= 11) e1++;
        else if (i <= 31) e2++;
      end
      snap[2] = (i == 10) || (i == 30);
      @(negedge clk);
      if (svld[2]) begin
        if (k < 2) begin cs[k] = int'(c_sop); ce[k] = int'(c_eop); cr[k] = int'(c_err); end
        k++;
      end
    end
    snap[2] = 1'b0;
    idle(2);
    checks++;
    if (k !== 2) begin errors++; $display("FAIL cos_vld_count got %0d exp 2", k); end
    checks++;
    if (cs[0] !== 12 || ce[0] !== 12) begin errors++; $display("FAIL cos_snap1 got %0d/%0d exp 12/12", cs[0], ce[0]); end
    checks++;
    if (cr[0] !== e1) begin errors++; $display("FAIL cos_snap1_err got %0d exp %0d", cr[0], e1); end
    checks++;
    if (cs[1] !== 20 || ce[1] !== 20) begin errors++; $display("FAIL cos_snap2 got %0d/%0d exp 20/20", cs[1], ce[1]); end
    checks++;
    if (cr[1] !== e2) begin errors++; $display("FAIL cos_snap2_err got %0d exp %0d", cr[1], e2); end
  endtask

  task automatic test_busy_ignore();
    int lat, nvld, vs, ve, vr;
    logic [2:0] vo;
    logic b1, b5;
    seg_clear();
    for (int i = 0; i < 20; i++) seg_beat(1'b1, 8'($urandom), 16'($urandom));
    idle(4);
    do_snap(1, -1, 2, lat, nvld, vs, ve, vr, vo, b1, b5);
    checks++;
    if (nvld !== 1 || lat !== 5) begin errors++; $display("FAIL busy_ignore got vld=%0d lat=%0d exp 1/5", nvld, lat); end
    checks++;
    if (b1 !== 1'b1 || b5 !== 1'b0) begin errors++; $display("FAIL busy_ignore_busy got %b%b exp 10", b1, b5); end
    checks++;
    if (vs !== exp_cnt(m_sop, 16) || ve !== exp_cnt(m_eop, 16) || vr !== exp_cnt(m_err, 16)) begin
      errors++;
      $display("FAIL busy_ignore_counts got %0d/%0d/%0d exp %0d/%0d/%0d", vs, ve, vr,
               exp_cnt(m_sop, 16), exp_cnt(m_eop, 16), exp_cnt(m_err, 16));
    end
  endtask

  task automatic test_rst_mid_snap();
    int nv;
    seg_beat(1'b1, 8'h0F, 16'h0000);
    idle(4);
    snap[1] = 1'b1;
    @(negedge clk);
    snap[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_sop = 0; m_eop = 0; m_err = 0; m_last = 1'b0;
    a_m_sop = 0; a_m_eop = 0; a_m_err = 0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (svld[1]) nv++;
    end
    checks++;
    if (nv !== 0) begin errors++; $display("FAIL rst_mid_snap_vld got %0d exp 0", nv); end
    checks++;
    if (busy[1] !== 1'b0 || (s_sop | s_eop | s_err) !== 16'h0) begin
      errors++; $display("FAIL rst_mid_snap_state got busy=%b sop=%0d exp 0/0", busy[1], s_sop);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr = '0; snap = '0;
    valid = 1'b0; sop = 1'b0; eop = 1'b0; error = '0;
    mvalid = 1'b0; inframe = '0; merr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_avst_wrap();
    test_seg_basic();
    test_seg_gap();
    test_seg_random();
    test_clr_on_latch();
    test_clr_on_snap();
    test_busy_ignore();
    test_rst_mid_snap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
